instr_fetch_ctrl: RTL

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

---
 rtl/instr_fetch_ctrl_pkg.sv | 16 +
 rtl/instr_fetch_ctrl_line_buffer.sv | 39 +++
 rtl/instr_fetch_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared definitions for the byte-serial instruction fetch controller:
// FSM states, word geometry and default parameter values.
package instr_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    COMMIT,
    ERROR
  } fetch_state_e;

  localparam int BYTES_PER_WORD     = 4;
  localparam int DEFAULT_ADDR_WIDTH = 10;
  localparam int DEFAULT_MAX_WAIT   = 15;

endpackage

// File: rtl/instr_fetch_ctrl_line_buffer.sv
// One-entry instruction line buffer: tag (full PC), valid bit and word,
// with a combinational hit compare against the requested PC.
module instr_line_buffer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        write_i,
  input  logic [31:0] tag_i,
  input  logic [31:0] data_i,
  input  logic [31:0] pc_i,
  output logic        hit_o,
  output logic [31:0] data_o
);

  logic [31:0] tag_q;
  logic [31:0] data_q;
  logic        valid_q;

  // Clear takes priority so a faulting fetch can never leave a stale word behind.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tag_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (clear_i) begin
      tag_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (write_i) begin
      tag_q   <= tag_i;
      data_q  <= data_i;
      valid_q <= 1'b1;
    end
  end

  assign hit_o  = valid_q && (pc_i == tag_q);
  assign data_o = data_q;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: assembles 32-bit big-endian words from a
// byte-wide memory into a one-entry line buffer and stalls the CPU on misses.
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int MAX_WAIT   = DEFAULT_MAX_WAIT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           pc_i,
  output logic [31:0]           instruction_o,
  output logic                  busy_wait_o,
  output logic                  fault_o,
  output logic                  mem_read_o,
  output logic [ADDR_WIDTH-1:0] mem_address_o,
  input  logic [7:0]            mem_readdata_i,
  input  logic                  mem_busywait_i
);

  localparam int          WaitW    = $clog2(MAX_WAIT + 2);
  localparam logic [1:0]  LastByte = 2'(BYTES_PER_WORD - 1);

  fetch_state_e          state_q, state_d;
  logic [31:0]           fetchPc_q, fetchPc_d;
  logic [1:0]            byteIdx_q, byteIdx_d;
  logic [WaitW-1:0]      waitCnt_q, waitCnt_d;
  logic [23:0]           asm_q, asm_d;
  logic                  fault_q, fault_d;
  logic [ADDR_WIDTH-1:0] memAddr_q;
  logic [ADDR_WIDTH-1:0] fetchAddr;
  logic                  hit, pcBad, bufWrite, bufClear, busy, memRead;
  logic [31:0]           bufData;

  assign pcBad     = (pc_i[1:0] != 2'b00) || ((pc_i >> ADDR_WIDTH) != 32'd0);
  assign fetchAddr = {fetchPc_q[ADDR_WIDTH-1:2], byteIdx_q};

  instr_line_buffer u_line_buffer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (bufClear),
    .write_i (bufWrite),
    .tag_i   (fetchPc_q),
    .data_i  ({asm_q, mem_readdata_i}),
    .pc_i    (pc_i),
    .hit_o   (hit),
    .data_o  (bufData)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      fetchPc_q <= '0;
      byteIdx_q <= '0;
      waitCnt_q <= '0;
      asm_q     <= '0;
      fault_q   <= 1'b0;
      memAddr_q <= '0;
    end else begin
      state_q   <= state_d;
      fetchPc_q <= fetchPc_d;
      byteIdx_q <= byteIdx_d;
      waitCnt_q <= waitCnt_d;
      asm_q     <= asm_d;
      fault_q   <= fault_d;
      if (state_q == FETCH) memAddr_q <= fetchAddr;
    end
  end

  // The final byte is written straight into the buffer on the edge that
  // enters COMMIT, so a zero-wait miss stalls for exactly five edges.
  always_comb begin
    state_d   = state_q;
    fetchPc_d = fetchPc_q;
    byteIdx_d = byteIdx_q;
    waitCnt_d = waitCnt_q;
    asm_d     = asm_q;
    fault_d   = fault_q;
    bufWrite  = 1'b0;
    bufClear  = 1'b0;
    busy      = 1'b0;
    memRead   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!hit) begin
          busy = 1'b1;
          if (pcBad) begin
            state_d = ERROR;
          end else begin
            state_d   = FETCH;
            fetchPc_d = pc_i;
            byteIdx_d = '0;
            waitCnt_d = '0;
          end
        end
      end
      FETCH: begin
        busy    = 1'b1;
        memRead = 1'b1;
        if (pc_i != fetchPc_q) begin
          if (pcBad) begin
            state_d = ERROR;
          end else begin
            fetchPc_d = pc_i;
            byteIdx_d = '0;
            waitCnt_d = '0;
          end
        end else if (mem_busywait_i) begin
          if (waitCnt_q == WaitW'(MAX_WAIT)) state_d = ERROR;
          else waitCnt_d = waitCnt_q + WaitW'(1);
        end else begin
          waitCnt_d = '0;
          byteIdx_d = byteIdx_q + 2'd1;
          if (byteIdx_q == LastByte) begin
            bufWrite = 1'b1;
            state_d  = COMMIT;
          end else begin
            asm_d = {asm_q[15:0], mem_readdata_i};
          end
        end
      end
      COMMIT: begin
        busy    = !hit;
        state_d = IDLE;
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: state_d = IDLE;
    endcase
    // Faults are flagged and the buffer wiped on the same edge that enters ERROR.
    if (state_d == ERROR) begin
      fault_d  = 1'b1;
      bufClear = 1'b1;
    end
  end

  assign busy_wait_o   = busy && !rst_i;
  assign mem_read_o    = memRead;
  assign mem_address_o = (state_q == FETCH) ? fetchAddr : memAddr_q;
  assign fault_o       = fault_q;
  assign instruction_o = bufData;

endmodule
